// File: rtl/updn_mod_counter.sv
// Modulo up/down counter with programmable terminal value, synchronous load,
// count enable and a registered wrap pulse. Define UDC_SAT_EN to add the sat port.
module updn_mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UDC_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic [WIDTH-1:0] next_count_s;
    logic             next_wrap_s;
    logic             sat_s;

`ifdef UDC_SAT_EN
    assign sat_s = sat;
`else
    assign sat_s = 1'b0;
`endif

    // Next-state selection: load beats enable; terminal checks precede the +/-1
    // so no carry or borrow ever reaches the count register.
    always_comb begin
        next_count_s = count_r;
        next_wrap_s  = 1'b0;
        if (load) begin
            if (load_val > limit) begin
                next_count_s = limit;
            end else begin
                next_count_s = load_val;
            end
        end else if (en) begin
            if (mode) begin
                if (count_r >= limit) begin
                    if (sat_s) begin
                        next_count_s = limit;
                    end else begin
                        next_count_s = ZERO_V;
                        next_wrap_s  = 1'b1;
                    end
                end else begin
                    next_count_s = count_r + ONE_V;
                end
            end else begin
                if (count_r > limit) begin
                    next_count_s = limit;
                    next_wrap_s  = ~sat_s;
                end else if (count_r == ZERO_V) begin
                    if (sat_s) begin
                        next_count_s = ZERO_V;
                    end else begin
                        next_count_s = limit;
                        next_wrap_s  = 1'b1;
                    end
                end else begin
                    next_count_s = count_r - ONE_V;
                end
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // Count and wrap registers, cleared asynchronously by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_r <= ZERO_V;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= next_count_s;
            wrap_r  <= next_wrap_s;
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;
    assign zero  = (count_r == ZERO_V);

endmodule

// File: tb/tb_updn_mod_counter.sv
// Randomized self-checking bench for updn_mod_counter (WIDTH=4) against an
// integer reference model; saturation tests run when UDC_SAT_EN is defined.
module tb_updn_mod_counter;

    logic       clk;
    logic       clr;
    logic       en;
    logic       mode;
    logic [3:0] limit;
    logic       load;
    logic [3:0] load_val;
    logic       sat;
    logic [3:0] count;
    logic       wrap;
    logic       zero;

    int n_checks = 0;
    int n_pass   = 0;
    int m_count  = 0;
    int m_wrap   = 0;

    updn_mod_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .mode     (mode),
        .limit    (limit),
        .load     (load),
        .load_val (load_val),
`ifdef UDC_SAT_EN
        .sat      (sat),
`endif
        .count    (count),
        .wrap     (wrap),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, int'(count), m_count);
        check({tag, ".wrap"},  int'(wrap),  m_wrap);
        check({tag, ".zero"},  int'(zero),  (m_count == 0) ? 1 : 0);
    endtask

    // Reference behaviour, stated directly from the counter's rules in integers.
    task automatic model_step();
        int lim;
        int sat_on;
        lim = int'(limit);
`ifdef UDC_SAT_EN
        sat_on = int'(sat);
`else
        sat_on = 0;
`endif
        if (clr) begin
            m_count = 0;
            m_wrap  = 0;
        end else if (load) begin
            m_count = (int'(load_val) > lim) ? lim : int'(load_val);
            m_wrap  = 0;
        end else if (en) begin
            if (sat_on != 0) begin
                if (mode) m_count = (m_count >= lim) ? lim : m_count + 1;
                else      m_count = (m_count > lim) ? lim : ((m_count == 0) ? 0 : m_count - 1);
                m_wrap = 0;
            end else if (mode) begin
                m_wrap  = (m_count >= lim) ? 1 : 0;
                m_count = (m_count >= lim) ? 0 : m_count + 1;
            end else begin
                m_wrap  = (m_count == 0 || m_count > lim) ? 1 : 0;
                m_count = (m_wrap != 0) ? lim : m_count - 1;
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Raise clr between edges, confirm the immediate clear, hold it over one edge.
    task automatic clear_mid(input string tag);
        #2;
        clr = 1'b1;
        #1;
        m_count = 0;
        m_wrap  = 0;
        check_all({tag, ".async"});
        tick({tag, ".held"});
        clr = 1'b0;
    endtask

    initial begin
        clk = 1'b0; clr = 1'b1; en = 1'b0; mode = 1'b1; limit = 4'd0;
        load = 1'b0; load_val = 4'd0; sat = 1'b0;
        #3;
        check_all("reset");
        tick("reset_edge");
        clr = 1'b0;

        limit = 4'd10; mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 12; i++) tick("wrap_up");

        en = 1'b0; load = 1'b1; load_val = 4'd0;
        tick("load0");
        load = 1'b0; limit = 4'd15; mode = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) tick("wrap_down");

        limit = 4'd9; load_val = 4'd12; load = 1'b1; en = 1'b1; mode = 1'b1;
        tick("load_clamp");
        load_val = 4'd3;
        tick("load_3");
        load = 1'b0;

        limit = 4'd15; load = 1'b1; load_val = 4'd8;
        tick("load8_a");
        load = 1'b0; limit = 4'd5; mode = 1'b1; en = 1'b1;
        tick("lower_up");
        limit = 4'd15; load = 1'b1; load_val = 4'd8;
        tick("load8_b");
        load = 1'b0; limit = 4'd5; mode = 1'b0;
        tick("lower_down");

        en = 1'b0;
        tick("hold_a");
        tick("hold_b");

        limit = 4'd7; load = 1'b1; load_val = 4'd0;
        tick("load0_b");
        load = 1'b0; mode = 1'b0; en = 1'b1;
        tick("to_seven");
        clear_mid("clr_mid");

        limit = 4'd0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mode = i[0];
            tick("limit0");
        end

`ifdef UDC_SAT_EN
        sat = 1'b1; limit = 4'd4; load = 1'b1; load_val = 4'd0;
        tick("sat_load0");
        load = 1'b0; mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 6; i++) tick("sat_up");
        load = 1'b1; load_val = 4'd1;
        tick("sat_load1");
        load = 1'b0; mode = 1'b0;
        tick("sat_down_a");
        tick("sat_down_b");
        sat = 1'b0;
`endif

        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            mode     = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 11) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) limit = 4'($urandom_range(0, 15));
`ifdef UDC_SAT_EN
            if ($urandom_range(0, 19) == 0) sat = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 59) == 0) begin
                clear_mid("rnd_clr");
            end else begin
                tick("random");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/updn_mod_counter.md
# updn_mod_counter

Parametrised modulo up/down counter with runtime-programmable terminal value, synchronous load, count enable and a registered wrap pulse. Generalises the fixed 4-bit up/down counter to WIDTH bits and adds load, enable, wrap signalling and optional saturation. Used wherever the design needs a divide-by-N or position counter whose direction and limit change at run time.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..32.
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  asynchronous, active-high reset.
- en  in  1  count enable; no count step when 0.
- mode  in  1  direction: 1 = up, 0 = down.
- limit  in  WIDTH  terminal value N; count range is 0..N inclusive.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- sat  in  1  saturate instead of wrap (present only with UDC_SAT_EN).
- count  out  WIDTH  current count, registered.
- wrap  out  1  registered one-cycle pulse, high after an edge that wrapped.
- zero  out  1  combinational, count == 0.

## Operation
- Priority per edge: clr > load > en > hold.
- load=1: count <= (load_val > limit) ? limit : load_val. wrap <= 0. en and mode ignored that edge.
- en=1, mode=1 (up):
  - count < limit: count <= count+1, wrap <= 0.
  - count == limit: count <= 0, wrap <= 1.
  - count > limit (limit lowered while running): count <= 0, wrap <= 1.
- en=1, mode=0 (down):
  - 0 < count <= limit: count <= count-1, wrap <= 0.
  - count == 0: count <= limit, wrap <= 1.
  - count > limit: count <= limit, wrap <= 1.
- en=0, load=0: count holds, wrap <= 0.
- limit == 0: count stays 0 whenever enabled; every enabled edge in either direction produces wrap=1.
- All arithmetic is unsigned, WIDTH bits; no intermediate carry or borrow ever reaches count (wrap logic precedes increment/decrement).
- mode, limit and sat are sampled on the same edge as en; changes take effect on the next enabled edge with no pipeline.

## Timing
- Reset values: count = 0, wrap = 0, zero = 1.
- clr assertion clears count and wrap immediately, without waiting for clk. While clr is high, load and en are ignored.
- First count step after clr deasserts occurs on the first rising edge with clr low and en=1.
- Latency: count and wrap reflect the inputs sampled at edge k immediately after edge k (one register stage). zero follows count combinationally.
- wrap is high for exactly one cycle per wrap event. Back-to-back wraps (for example limit=0, en held high) keep wrap high continuously.
- clr during a wrap cycle forces wrap low at once.

## Configuration
- UDC_SAT_EN defined: port sat exists.
  - With sat=1, up-count at count >= limit holds count at limit, and down-count at count == 0 holds 0. No wrap is asserted.
  - count > limit with sat=1 clamps to limit in either direction; wrap stays 0.
  - With sat=0, behaviour is identical to the undefined case.
- UDC_SAT_EN undefined: no sat port; wrap behaviour only; no saturation logic synthesised.

## Test plan
- Reset and wrap-up:
  - Stimulus: WIDTH=4, pulse clr, then limit=10, mode=1, en=1 for 12 edges.
  - Required: count 1..10, then 0; wrap high only in the cycle count returns to 0; zero=1 after reset.
- Wrap-down:
  - Stimulus: limit=15, mode=0, en=1 from count=0.
  - Required: count 15 with wrap=1 on the first edge, then 14, 13, ... with wrap=0.
- Load clamp and priority:
  - Stimulus: limit=9, load_val=12, load=1 together with en=1.
  - Required: count=9, wrap=0. Then load_val=3 gives count=3.
- Limit lowered mid-count:
  - Stimulus: count=8, limit changed to 5, en=1.
  - Required: up gives count 0 with wrap=1; down gives count 5 with wrap=1.
- Asynchronous clear mid-operation:
  - Stimulus: assert clr between clock edges while count=7 and wrap=1.
  - Required: count=0 and wrap=0 before the next edge; no count steps while clr is high.
- Saturation (UDC_SAT_EN defined):
  - Stimulus: sat=1, limit=4, mode=1, 6 enabled edges from 0.
  - Required: count 1, 2, 3, 4, 4, 4; wrap stays 0. Then mode=0 from count 1 gives 0, 0.
